multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; low forces the controller into IDLE immediately, independent of clk.
REQ-003 OP  input  6  opcode field of the instruction register (IR[31:26]); sampled in DECODE only.
REQ-004 MemReady  input  1  memory handshake; high in a cycle where MemRead or MemWrite is high means the access completes in that cycle.
REQ-005 PCWrite, PCWriteCondEQ, PCWriteCondNE  output  1 each  unconditional / zero-taken / nonzero-taken PC write enables.
REQ-006 IorD, MemRead, MemWrite, IRWrite  output  1 each  address mux select (0=PC, 1=ALUOut), memory strobes, IR load.
REQ-007 RegDst, MemtoReg, RegWrite, ALUSrcA  output  1 each  register-file and ALU operand-A controls (ALUSrcA 0=PC, 1=rs).
REQ-008 ALUSrcB  output  2  00=rt, 01=constant 4, 10=sign-ext imm, 11=sign-ext imm<<2.
REQ-009 PCSource  output  2  00=ALU result, 01=ALUOut, 10=jump target.
REQ-010 ALUOp  output  4  ALU control code: 0111 R-type funct, 0100 add, 0101 or, 0110 and, 0001 subtract, 1000 lui.
REQ-011 IllegalOp  output  1  one-cycle pulse on an unsupported opcode.

Function
REQ-012 Controller SHALL be a Moore FSM; every output a pure function of the current state; any output not listed for a state is 0.
REQ-013 States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, ILLEGAL.
REQ-014 IDLE: all outputs 0; unconditional next FETCH.
REQ-015 FETCH: MemRead, IRWrite, PCWrite, ALUSrcB=01, ALUOp=0100, PCSource=00, IorD=0; hold FETCH while MemReady=0 with IRWrite/PCWrite gated low; MemReady=1 -> DECODE.
REQ-016 DECODE: ALUSrcB=11, ALUOp=0100 (branch target into ALUOut); next by OP: 0x00->R_EXEC; 0x08/0x0C/0x0D/0x0F->I_EXEC; 0x23/0x2B->MEM_ADDR; 0x04/0x05->BRANCH; 0x02/0x03->JUMP; other->ILLEGAL.
REQ-017 OP SHALL be latched into an internal opcode register in DECODE; later states use the latched value only.
REQ-018 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=0100; LW->MEM_RD, SW->MEM_WR.
REQ-019 MEM_RD: MemRead, IorD=1; wait while MemReady=0; then MEM_WB.
REQ-020 MEM_WB: RegWrite, MemtoReg=1, RegDst=0; next FETCH.
REQ-021 MEM_WR: MemWrite, IorD=1; wait while MemReady=0; then FETCH.
REQ-022 R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=0111; next R_WB. R_WB: RegWrite, RegDst=1; next FETCH.
REQ-023 I_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp 0100/0110/0101/1000 for ADDI/ANDI/ORI/LUI; next I_WB. I_WB: RegWrite, RegDst=0; next FETCH.
REQ-024 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=0001, PCSource=01, PCWriteCondEQ for BEQ or PCWriteCondNE for BNE; next FETCH.
REQ-025 JUMP: PCWrite, PCSource=10; next FETCH.
REQ-026 ILLEGAL: IllegalOp=1, no other output; next FETCH.
REQ-027 Cycle counts with MemReady tied high: LW 5, SW 4, R/I 4, BEQ/BNE 3, J 3; each MemReady=0 cycle adds one.
REQ-028 MemRead and MemWrite SHALL never be high together; RegWrite SHALL never be high in a memory-wait cycle.

Reset
REQ-029 reset low: state=IDLE, latched opcode=0, all outputs 0 within the same cycle, including mid-wait in FETCH/MEM_RD/MEM_WR.
REQ-030 First FETCH occurs on the second rising clk edge after reset deasserts (IDLE->FETCH on first edge).

Structure
REQ-031 State encodings, opcode constants and ALUOp codes SHALL reside in a shared package used by this block and the single-cycle control path.
REQ-032 A sub-module multicycle_control_outdec SHALL map state and latched opcode to outputs; the top holds state register, opcode latch and next-state logic.

Verification
REQ-033 Reset release, MemReady=1 -> IDLE, then FETCH with MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01.
REQ-034 OP=0x23, MemReady=1 -> FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB; RegWrite=1, MemtoReg=1 only in cycle 5.
REQ-035 OP=0x2B, MemReady low 3 cycles in MEM_WR -> MemWrite held 4 cycles, FETCH follows the MemReady=1 cycle.
REQ-036 OP=0x05 -> BRANCH with PCWriteCondNE=1, PCWriteCondEQ=0, ALUOp=0001, PCSource=01; OP=0x02 -> JUMP with PCWrite=1, PCSource=10.
REQ-037 OP=0x3F -> ILLEGAL, IllegalOp high exactly one cycle, then FETCH.
REQ-038 reset asserted during MEM_RD wait -> all outputs 0 immediately; after release IDLE then FETCH.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle and single-cycle control paths:
// controller state encoding, opcode constants, ALU control codes, mux select
// codes and the packed control word produced by the output decoder.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StDecode,
    StMemAddr,
    StMemRd,
    StMemWb,
    StMemWr,
    StRExec,
    StRWb,
    StIExec,
    StIWb,
    StBranch,
    StJump,
    StIllegal
  } stateT;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OpRType = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  // ALU control codes
  localparam logic [3:0] AluSub   = 4'b0001;
  localparam logic [3:0] AluAdd   = 4'b0100;
  localparam logic [3:0] AluOr    = 4'b0101;
  localparam logic [3:0] AluAnd   = 4'b0110;
  localparam logic [3:0] AluFunct = 4'b0111;
  localparam logic [3:0] AluLui   = 4'b1000;

  // ALU operand-B select
  localparam logic [1:0] SrcBRt     = 2'b00;
  localparam logic [1:0] SrcBFour   = 2'b01;
  localparam logic [1:0] SrcBImm    = 2'b10;
  localparam logic [1:0] SrcBImmSh2 = 2'b11;

  // PC source select
  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCondEq;
    logic       pcWriteCondNe;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       memtoReg;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] pcSource;
    logic [3:0] aluOp;
    logic       illegalOp;
  } ctrlT;

  // ALU operation for the immediate-arithmetic group
  function automatic logic [3:0] immAluOp(input logic [5:0] op);
    case (op)
      OpAndi:  immAluOp = AluAnd;
      OpOri:   immAluOp = AluOr;
      OpLui:   immAluOp = AluLui;
      default: immAluOp = AluAdd;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle controller and the datapath.
//   OP, MemReady        : datapath -> controller (opcode field, memory handshake)
//   PCWrite..IllegalOp  : controller -> datapath control strobes and selects
// master = controller, slave = datapath.
interface multicycle_control_if;
  logic [5:0] OP;
  logic       MemReady;
  logic       PCWrite;
  logic       PCWriteCondEQ;
  logic       PCWriteCondNE;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic [3:0] ALUOp;
  logic       IllegalOp;

  modport master (
    input  OP, MemReady,
    output PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite, IRWrite,
           RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, IllegalOp
  );

  modport slave (
    output OP, MemReady,
    input  PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite, IRWrite,
           RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, IllegalOp
  );
endinterface

// File: rtl/multicycle_control_outdec.sv
// Output decoder: maps controller state and latched opcode to the control word.
//   state     : current controller state
//   opLatched : opcode captured in DECODE
//   memReady  : memory handshake, only used to gate the FETCH commit strobes
//   ctrl      : control word, all fields 0 unless set for the state
module multicycle_control_outdec
  import multicycle_control_pkg::*;
(
  input  stateT      state,
  input  logic [5:0] opLatched,
  input  logic       memReady,
  output ctrlT       ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      StFetch: begin
        ctrl.memRead = 1'b1;
        // IR and PC only commit on the cycle the fetch completes
        ctrl.irWrite = memReady;
        ctrl.pcWrite = memReady;
        ctrl.aluSrcB = SrcBFour;
        ctrl.aluOp   = AluAdd;
      end
      StDecode: begin
        ctrl.aluSrcB = SrcBImmSh2;
        ctrl.aluOp   = AluAdd;
      end
      StMemAddr: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SrcBImm;
        ctrl.aluOp   = AluAdd;
      end
      StMemRd: begin
        ctrl.memRead = 1'b1;
        ctrl.iorD    = 1'b1;
      end
      StMemWb: begin
        ctrl.regWrite = 1'b1;
        ctrl.memtoReg = 1'b1;
      end
      StMemWr: begin
        ctrl.memWrite = 1'b1;
        ctrl.iorD     = 1'b1;
      end
      StRExec: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SrcBRt;
        ctrl.aluOp   = AluFunct;
      end
      StRWb: begin
        ctrl.regWrite = 1'b1;
        ctrl.regDst   = 1'b1;
      end
      StIExec: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SrcBImm;
        ctrl.aluOp   = immAluOp(opLatched);
      end
      StIWb: begin
        ctrl.regWrite = 1'b1;
      end
      StBranch: begin
        ctrl.aluSrcA       = 1'b1;
        ctrl.aluSrcB       = SrcBRt;
        ctrl.aluOp         = AluSub;
        ctrl.pcSource      = PcSrcAluOut;
        ctrl.pcWriteCondEq = (opLatched == OpBeq);
        ctrl.pcWriteCondNe = (opLatched == OpBne);
      end
      StJump: begin
        ctrl.pcWrite  = 1'b1;
        ctrl.pcSource = PcSrcJump;
      end
      StIllegal: begin
        ctrl.illegalOp = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style main controller.
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset, forces IDLE
//   bus   : master side of the control bus (OP/MemReady in, control strobes out)
// Holds the state register, the opcode latch and next-state logic; outputs come
// from multicycle_control_outdec.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  stateT      stateQ, stateD;
  logic [5:0] opQ;
  ctrlT       ctrl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ <= StIdle;
      opQ    <= '0;
    end else begin
      stateQ <= stateD;
      if (stateQ == StDecode) opQ <= bus.OP;
    end
  end

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      StIdle:   stateD = StFetch;
      StFetch:  if (bus.MemReady) stateD = StDecode;
      StDecode: begin
        case (bus.OP)
          OpRType:                      stateD = StRExec;
          OpAddi, OpAndi, OpOri, OpLui: stateD = StIExec;
          OpLw, OpSw:                   stateD = StMemAddr;
          OpBeq, OpBne:                 stateD = StBranch;
          OpJ, OpJal:                   stateD = StJump;
          default:                      stateD = StIllegal;
        endcase
      end
      StMemAddr: stateD = (opQ == OpSw) ? StMemWr : StMemRd;
      StMemRd:   if (bus.MemReady) stateD = StMemWb;
      StMemWb:   stateD = StFetch;
      StMemWr:   if (bus.MemReady) stateD = StFetch;
      StRExec:   stateD = StRWb;
      StRWb:     stateD = StFetch;
      StIExec:   stateD = StIWb;
      StIWb:     stateD = StFetch;
      StBranch:  stateD = StFetch;
      StJump:    stateD = StFetch;
      StIllegal: stateD = StFetch;
      default:   stateD = StIdle;
    endcase
  end

  multicycle_control_outdec uOutdec (
    .state     (stateQ),
    .opLatched (opQ),
    .memReady  (bus.MemReady),
    .ctrl      (ctrl)
  );

  assign bus.PCWrite       = ctrl.pcWrite;
  assign bus.PCWriteCondEQ = ctrl.pcWriteCondEq;
  assign bus.PCWriteCondNE = ctrl.pcWriteCondNe;
  assign bus.IorD          = ctrl.iorD;
  assign bus.MemRead       = ctrl.memRead;
  assign bus.MemWrite      = ctrl.memWrite;
  assign bus.IRWrite       = ctrl.irWrite;
  assign bus.RegDst        = ctrl.regDst;
  assign bus.MemtoReg      = ctrl.memtoReg;
  assign bus.RegWrite      = ctrl.regWrite;
  assign bus.ALUSrcA       = ctrl.aluSrcA;
  assign bus.ALUSrcB       = ctrl.aluSrcB;
  assign bus.PCSource      = ctrl.pcSource;
  assign bus.ALUOp         = ctrl.aluOp;
  assign bus.IllegalOp     = ctrl.illegalOp;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: each instruction is expanded into the list of
// control words it should produce, cycle by cycle, with memory waits inserted.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Control word layout: {PCWrite,CondEQ,CondNE,IorD,MemRead,MemWrite,IRWrite,
  //                       RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,PCSource,ALUOp,IllegalOp}
  localparam logic [19:0] WPcw  = 20'h1 << 19;
  localparam logic [19:0] WEq   = 20'h1 << 18;
  localparam logic [19:0] WNe   = 20'h1 << 17;
  localparam logic [19:0] WIord = 20'h1 << 16;
  localparam logic [19:0] WMr   = 20'h1 << 15;
  localparam logic [19:0] WMw   = 20'h1 << 14;
  localparam logic [19:0] WIrw  = 20'h1 << 13;
  localparam logic [19:0] WRdst = 20'h1 << 12;
  localparam logic [19:0] WM2r  = 20'h1 << 11;
  localparam logic [19:0] WRw   = 20'h1 << 10;
  localparam logic [19:0] WSrcA = 20'h1 << 9;
  localparam logic [19:0] WIll  = 20'h1;

  function automatic logic [19:0] srcB(input logic [1:0] v);
    return {11'b0, v, 7'b0};
  endfunction
  function automatic logic [19:0] pcs(input logic [1:0] v);
    return {13'b0, v, 5'b0};
  endfunction
  function automatic logic [19:0] alu(input logic [3:0] v);
    return {15'b0, v, 1'b0};
  endfunction

  typedef struct {
    string       name;
    logic [19:0] w;      // word when the step completes
    logic [19:0] wWait;  // word while stalled on MemReady=0
    bit          waits;
    int          zeros;  // MemReady-low cycles to insert
  } phaseT;

  phaseT      q[$];
  logic [5:0] curOp;

  function automatic logic [19:0] obs();
    return {bus.PCWrite, bus.PCWriteCondEQ, bus.PCWriteCondNE, bus.IorD, bus.MemRead,
            bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg, bus.RegWrite, bus.ALUSrcA,
            bus.ALUSrcB, bus.PCSource, bus.ALUOp, bus.IllegalOp};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s op=%h got=%h exp=%h t=%0t", tag, curOp, got, exp, $time);
    end
  endtask

  function automatic phaseT ph(input string n, input logic [19:0] w, input logic [19:0] ww,
                               input bit wt, input int z);
    phaseT p;
    p.name = n; p.w = w; p.wWait = ww; p.waits = wt; p.zeros = z;
    return p;
  endfunction

  task automatic buildInstr(input logic [5:0] op, input int zf, input int zm);
    logic [3:0] iop;
    curOp = op;
    q.delete();
    q.push_back(ph("fetch", WPcw | WMr | WIrw | srcB(2'b01) | alu(4'b0100),
                   WMr | srcB(2'b01) | alu(4'b0100), 1, zf));
    q.push_back(ph("decode", srcB(2'b11) | alu(4'b0100), '0, 0, 0));
    case (op)
      6'h23: begin
        q.push_back(ph("lw_addr", WSrcA | srcB(2'b10) | alu(4'b0100), '0, 0, 0));
        q.push_back(ph("lw_read", WIord | WMr, WIord | WMr, 1, zm));
        q.push_back(ph("lw_wb", WRw | WM2r, '0, 0, 0));
      end
      6'h2B: begin
        q.push_back(ph("sw_addr", WSrcA | srcB(2'b10) | alu(4'b0100), '0, 0, 0));
        q.push_back(ph("sw_write", WIord | WMw, WIord | WMw, 1, zm));
      end
      6'h00: begin
        q.push_back(ph("r_exec", WSrcA | srcB(2'b00) | alu(4'b0111), '0, 0, 0));
        q.push_back(ph("r_wb", WRw | WRdst, '0, 0, 0));
      end
      6'h08, 6'h0C, 6'h0D, 6'h0F: begin
        iop = (op == 6'h08) ? 4'b0100 : (op == 6'h0C) ? 4'b0110 :
              (op == 6'h0D) ? 4'b0101 : 4'b1000;
        q.push_back(ph("i_exec", WSrcA | srcB(2'b10) | alu(iop), '0, 0, 0));
        q.push_back(ph("i_wb", WRw, '0, 0, 0));
      end
      6'h04: q.push_back(ph("beq", WSrcA | alu(4'b0001) | pcs(2'b01) | WEq, '0, 0, 0));
      6'h05: q.push_back(ph("bne", WSrcA | alu(4'b0001) | pcs(2'b01) | WNe, '0, 0, 0));
      6'h02, 6'h03: q.push_back(ph("jump", WPcw | pcs(2'b10), '0, 0, 0));
      default: q.push_back(ph("illegal", WIll, '0, 0, 0));
    endcase
  endtask

  // Walk the expected steps; stopIdx/stopCyc allow leaving mid-step.
  task automatic runPhases(input int stopIdx, input int stopCyc);
    logic [19:0] exp;
    for (int i = 0; i < q.size(); i++) begin
      int n = 0;
      forever begin
        @(negedge clk);
        // OP is only meaningful in DECODE; garbage elsewhere exercises the latch
        bus.OP = (i == 1) ? curOp : 6'($urandom);
        bus.MemReady = q[i].waits ? (n >= q[i].zeros) : 1'($urandom);
        #1;
        exp = (q[i].waits && !bus.MemReady) ? q[i].wWait : q[i].w;
        check(q[i].name, 32'(obs()), 32'(exp));
        check("mem_excl", 32'(bus.MemRead & bus.MemWrite), 32'd0);
        n++;
        if (i == stopIdx && n == stopCyc) return;
        if (!q[i].waits || bus.MemReady) break;
      end
    end
  endtask

  task automatic runInstr(input logic [5:0] op, input int zf, input int zm);
    buildInstr(op, zf, zm);
    runPhases(-1, 0);
  endtask

  // Release reset at a falling edge and check the IDLE cycle
  task automatic releaseReset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("idle_after_reset", 32'(obs()), 32'd0);
  endtask

  logic [5:0] opList[13] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0C,
                            6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h3F, 6'h10};

  initial begin
    reset = 1'b0;
    bus.OP = '0;
    bus.MemReady = 1'b1;
    curOp = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_state", 32'(obs()), 32'd0);
    releaseReset();

    // Directed sequences
    runInstr(6'h23, 0, 0);
    runInstr(6'h2B, 0, 3);
    runInstr(6'h05, 0, 0);
    runInstr(6'h02, 0, 0);
    runInstr(6'h3F, 0, 0);
    runInstr(6'h00, 2, 0);
    runInstr(6'h08, 0, 0);
    runInstr(6'h0C, 0, 0);
    runInstr(6'h0D, 0, 0);
    runInstr(6'h0F, 0, 0);
    runInstr(6'h04, 0, 0);
    runInstr(6'h03, 0, 0);
    runInstr(6'h23, 1, 4);

    // Randomized instruction stream with random memory waits
    for (int k = 0; k < 200; k++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : opList[$urandom_range(0, 12)];
      runInstr(op, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Asynchronous reset in the middle of each kind of memory wait
    for (int v = 0; v < 3; v++) begin
      if (v == 0) begin buildInstr(6'h23, 0, 5); runPhases(3, 2); end
      else if (v == 1) begin buildInstr(6'h2B, 0, 5); runPhases(3, 3); end
      else begin buildInstr(6'h00, 5, 0); runPhases(0, 2); end
      #2;
      reset = 1'b0;
      #1;
      check("reset_midwait", 32'(obs()), 32'd0);
      @(negedge clk);
      #1;
      check("reset_held", 32'(obs()), 32'd0);
      releaseReset();
      runInstr(6'h23, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
